// File: rtl/icebreaker_pkg.sv
// rtl/icebreaker_pkg.sv - shared types for the main-memory arbiter
// Purpose: FSM state and access-owner enums plus sizing helpers used by
//          icebreaker_mem_arbiter and icebreaker_arb_starve.
// Ports:   none (package).
package icebreaker_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_e;
  typedef enum logic {OWN_INSTR, OWN_DATA} arb_owner_e;

  // Wait counter covers WAIT_STATES up to 3.
  localparam int WAIT_CNT_W = 2;

  // Starvation counter must hold 0..limit; a limit of 0 still needs one bit.
  function automatic int starve_cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/icebreaker_arb_starve.sv
// rtl/icebreaker_arb_starve.sv - data-priority winner select with instr anti-starvation
// Purpose: picks the owner of the next memory access. Data wins unless the
//          instr port has lost STARVE_LIMIT consecutive arbitrations.
// Ports:   clk, rstz      clock, async active-low reset
//          instr_req      instr port requesting
//          data_req       data port requesting (load or store)
//          arb_en         an arbitration happens this cycle
//          winner         owner chosen for this arbitration (combinational)
module icebreaker_arb_starve
  import icebreaker_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       instr_req,
  input  logic       data_req,
  input  logic       arb_en,
  output arb_owner_e winner
);

  localparam int            CW    = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          force_instr;

  // A limit of 0 disables forcing entirely: instr only wins when data is quiet.
  assign force_instr = instr_req && (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

  always_comb begin
    winner = (data_req && !force_instr) ? OWN_DATA : OWN_INSTR;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (winner == OWN_DATA && instr_req) begin
        if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + CW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/icebreaker_mem_arbiter.sv
// rtl/icebreaker_mem_arbiter.sv - single-port main memory sequencer for instr and data ports
// Purpose: shares one SPRAM between the core fetch and load/store ports,
//          one access in flight, all memory-side outputs registered.
// Ports:   clk, rstz                     clock, async active-low reset
//          instr_addr/req -> instr_gnt   fetch request, 1-cycle grant pulse
//          instr_data                    fetched word (memory read data)
//          data_addr/wr_data/wr_mask     load/store address, store data, byte enables
//          data_rd_req/wr_req -> data_gnt load/store request, 1-cycle grant pulse
//          data_rd_data                  load data (memory read data)
//          mem_addr/wr_data/wr_mask      registered memory address, write data, byte mask
//          mem_en/mem_wr_en              one-cycle access strobe and write strobe
//          mem_rd_data                   memory read data, valid 1+WAIT_STATES after mem_en
module icebreaker_mem_arbiter
  import icebreaker_pkg::*;
#(
  parameter int WAIT_STATES  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  output logic        data_gnt,
  output logic [31:0] data_rd_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] mem_wr_data,
  output logic        mem_en,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask
);

  arb_state_e            state;
  arb_owner_e            owner;
  arb_owner_e            winner;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  data_req;
  logic                  arb_en;

  assign data_req = data_rd_req | data_wr_req;
  assign arb_en   = (state == IDLE) && (instr_req || data_req);

  icebreaker_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rstz     (rstz),
    .instr_req(instr_req),
    .data_req (data_req),
    .arb_en   (arb_en),
    .winner   (winner)
  );

  // Read data is only meaningful while the owner's grant is high.
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state       <= IDLE;
      owner       <= OWN_INSTR;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr_mask <= '0;
      mem_en      <= 1'b0;
      mem_wr_en   <= 1'b0;
      instr_gnt   <= 1'b0;
      data_gnt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_en) begin
            owner  <= winner;
            mem_en <= 1'b1;
            state  <= ACCESS;
            if (winner == OWN_DATA) begin
              // Simultaneous load and store requests resolve to a store.
              mem_addr    <= data_addr;
              mem_wr_en   <= data_wr_req;
              mem_wr_data <= data_wr_data;
              mem_wr_mask <= data_wr_req ? data_wr_mask : 4'b0000;
            end else begin
              mem_addr    <= instr_addr;
              mem_wr_en   <= 1'b0;
              mem_wr_mask <= 4'b0000;
            end
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_wr_en <= 1'b0;
          if (WAIT_STATES == 0) begin
            instr_gnt <= (owner == OWN_INSTR);
            data_gnt  <= (owner == OWN_DATA);
            state     <= RESP;
          end else begin
            wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            instr_gnt <= (owner == OWN_INSTR);
            data_gnt  <= (owner == OWN_DATA);
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end
        end
        RESP: begin
          // Requests are ignored here so the requester can drop or replace them.
          instr_gnt <= 1'b0;
          data_gnt  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
